// File: rtl/bn_act_array_if.sv
// rtl/bn_act_array_if.sv - config, activation control and per-channel data bus of the post-array BN stage
interface bn_act_array_if #(
  parameter int CH       = 9,
  parameter int INT_BITS = 13
);
  logic                     weight_en_i;
  logic [2*INT_BITS-1:0]    config_in_i;
  logic [2*INT_BITS-1:0]    config_out_o;
  logic                     cfg_done_o;
  logic [1:0]               act_mode_i;
  logic [INT_BITS-1:0]      clip_max_i;
  logic [CH-1:0]            in_valid_i;
  logic [CH*INT_BITS-1:0]   in_i;
  logic [CH-1:0]            out_valid_o;
  logic [CH*INT_BITS-1:0]   out_o;
  logic                     sat_any_o;

  modport master (
    output weight_en_i, config_in_i, act_mode_i, clip_max_i, in_valid_i, in_i,
    input  config_out_o, cfg_done_o, out_valid_o, out_o, sat_any_o
  );

  modport slave (
    input  weight_en_i, config_in_i, act_mode_i, clip_max_i, in_valid_i, in_i,
    output config_out_o, cfg_done_o, out_valid_o, out_o, sat_any_o
  );
endinterface

// File: rtl/bn_act_array.sv
// rtl/bn_act_array.sv - per-channel batch-norm scale/bias, rounding, saturation, activation and optional deskew
module bn_act_array #(
  parameter int CH        = 9,
  parameter int INT_BITS  = 13,
  parameter int FRAC_BITS = 8,
  parameter int DESKEW    = 0
) (
  input  logic          clk_i,
  input  logic          reset_i,
  bn_act_array_if.slave bus
);
  localparam int W    = INT_BITS;
  localparam int PW   = 2 * INT_BITS + 1;
  localparam int SW   = PW + 2;
  localparam int CW   = $clog2(CH + 1);
  localparam int DLEN = (CH > 1) ? CH - 1 : 1;

  typedef logic signed [W-1:0]  data_t;
  typedef logic signed [PW-1:0] prod_t;
  typedef logic signed [SW-1:0] wide_t;

  localparam data_t SCALE_ONE = data_t'(1 << FRAC_BITS);
  localparam data_t DATA_MAX  = data_t'((1 << (W - 1)) - 1);
  localparam data_t DATA_MIN  = data_t'(-(1 << (W - 1)));

  data_t         scale_q [CH];
  data_t         scale_d [CH];
  data_t         bias_q  [CH];
  data_t         bias_d  [CH];
  logic [CW-1:0] cfg_cnt_q, cfg_cnt_d;
  logic          we_prev_q;
  logic          sat_any_q, sat_any_d;

  logic [CH-1:0] s1_v_q, s1_v_d;
  data_t         s1_x_q [CH];
  data_t         s1_x_d [CH];
  logic [CH-1:0] s2_v_q, s2_v_d;
  prod_t         s2_p_q [CH];
  prod_t         s2_p_d [CH];
  data_t         s2_b_q [CH];
  data_t         s2_b_d [CH];
  logic [CH-1:0] s3_v_q, s3_v_d;
  data_t         s3_x_q [CH];
  data_t         s3_x_d [CH];
  logic [CH-1:0] out_v_q, out_v_d;
  data_t         out_x_q [CH];
  data_t         out_x_d [CH];

  logic [CH-1:0] tap_v;
  data_t         tap_x [CH];
  wide_t         sum_w [CH];
  logic          we_rise;
  logic          sat_hit;

  function automatic wide_t bn_sum(input prod_t p, input data_t b);
    wide_t rnd;
    rnd = wide_t'(p) + (wide_t'(1) <<< (FRAC_BITS - 1));
    return (rnd >>> FRAC_BITS) + wide_t'(b);
  endfunction

  function automatic data_t activate(input data_t x, input logic [1:0] mode, input data_t clip);
    data_t a;
    case (mode)
      2'b01:   a = x[W-1] ? data_t'(0) : x;
      2'b10:   a = x[W-1] ? (x >>> 3) : x;
      2'b11:   a = x[W-1] ? data_t'(0) : ((x > clip) ? clip : x);
      default: a = x;
    endcase
    return a;
  endfunction

  always_comb begin
    we_rise   = bus.weight_en_i & ~we_prev_q;
    sat_hit   = 1'b0;
    scale_d   = scale_q;
    bias_d    = bias_q;
    cfg_cnt_d = cfg_cnt_q;

    if (bus.weight_en_i) begin
      scale_d[0] = data_t'(bus.config_in_i[2*W-1:W]);
      bias_d[0]  = data_t'(bus.config_in_i[W-1:0]);
      for (int i = 1; i < CH; i++) begin
        scale_d[i] = scale_q[i-1];
        bias_d[i]  = bias_q[i-1];
      end
      if (!we_prev_q) begin
        cfg_cnt_d = CW'(1);
      end else if (cfg_cnt_q != CW'(CH)) begin
        cfg_cnt_d = cfg_cnt_q + CW'(1);
      end
    end

    // bias travels with the product so a reload cannot corrupt samples in flight
    for (int i = 0; i < CH; i++) begin
      s1_v_d[i] = bus.in_valid_i[i] & ~bus.weight_en_i;
      s1_x_d[i] = data_t'(bus.in_i[i*W +: W]);
      s2_v_d[i] = s1_v_q[i];
      s2_p_d[i] = prod_t'(s1_x_q[i]) * prod_t'(scale_q[i]);
      s2_b_d[i] = bias_q[i];
      sum_w[i]  = bn_sum(s2_p_q[i], s2_b_q[i]);
      s3_v_d[i] = s2_v_q[i];
      if (sum_w[i] > wide_t'(DATA_MAX)) begin
        s3_x_d[i] = DATA_MAX;
        sat_hit   = sat_hit | s2_v_q[i];
      end else if (sum_w[i] < wide_t'(DATA_MIN)) begin
        s3_x_d[i] = DATA_MIN;
        sat_hit   = sat_hit | s2_v_q[i];
      end else begin
        s3_x_d[i] = data_t'(sum_w[i]);
      end
      out_v_d[i] = tap_v[i];
      out_x_d[i] = activate(tap_x[i], bus.act_mode_i, data_t'(bus.clip_max_i));
    end

    sat_any_d = we_rise ? 1'b0 : (sat_any_q | sat_hit);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < CH; i++) begin
        scale_q[i] <= SCALE_ONE;
        bias_q[i]  <= '0;
        s1_x_q[i]  <= '0;
        s2_p_q[i]  <= '0;
        s2_b_q[i]  <= '0;
        s3_x_q[i]  <= '0;
        out_x_q[i] <= '0;
      end
      cfg_cnt_q <= '0;
      we_prev_q <= 1'b0;
      sat_any_q <= 1'b0;
      s1_v_q    <= '0;
      s2_v_q    <= '0;
      s3_v_q    <= '0;
      out_v_q   <= '0;
    end else begin
      scale_q   <= scale_d;
      bias_q    <= bias_d;
      cfg_cnt_q <= cfg_cnt_d;
      we_prev_q <= bus.weight_en_i;
      sat_any_q <= sat_any_d;
      s1_v_q    <= s1_v_d;
      s1_x_q    <= s1_x_d;
      s2_v_q    <= s2_v_d;
      s2_p_q    <= s2_p_d;
      s2_b_q    <= s2_b_d;
      s3_v_q    <= s3_v_d;
      s3_x_q    <= s3_x_d;
      out_v_q   <= out_v_d;
      out_x_q   <= out_x_d;
    end
  end

  generate
    if (DESKEW != 0) begin : g_deskew
      logic  dly_v_q [CH][DLEN];
      data_t dly_x_q [CH][DLEN];

      always_ff @(posedge clk_i) begin
        for (int i = 0; i < CH; i++) begin
          for (int j = 0; j < DLEN; j++) begin
            if (reset_i) begin
              dly_v_q[i][j] <= 1'b0;
              dly_x_q[i][j] <= '0;
            end else if (j == 0) begin
              dly_v_q[i][j] <= s3_v_q[i];
              dly_x_q[i][j] <= s3_x_q[i];
            end else begin
              dly_v_q[i][j] <= dly_v_q[i][j-1];
              dly_x_q[i][j] <= dly_x_q[i][j-1];
            end
          end
        end
      end

      // lane i picks the tap that adds CH-1-i cycles; the last lane bypasses the line
      always_comb begin
        tap_v = s3_v_q;
        for (int i = 0; i < CH; i++) begin
          tap_x[i] = s3_x_q[i];
          for (int j = 0; j < DLEN; j++) begin
            if (j == CH - 2 - i) begin
              tap_v[i] = dly_v_q[i][j];
              tap_x[i] = dly_x_q[i][j];
            end
          end
        end
      end
    end else begin : g_no_deskew
      assign tap_v = s3_v_q;
      assign tap_x = s3_x_q;
    end
  endgenerate

  assign bus.config_out_o = {scale_q[CH-1], bias_q[CH-1]};
  assign bus.cfg_done_o   = (cfg_cnt_q == CW'(CH));
  assign bus.sat_any_o    = sat_any_q;
  assign bus.out_valid_o  = out_v_q;

  always_comb begin
    bus.out_o = '0;
    for (int i = 0; i < CH; i++) begin
      bus.out_o[i*W +: W] = out_x_q[i];
    end
  end
endmodule
